vc_output_arbiter: RTL and testbench
====================================

Name: vc_output_arbiter

Overview:
- Per-output-port scheduler for the mesh router.
- Shares one outbound link among NUM_REQ input requesters: N, S, E, W and PE.
- Holds two single-flit output buffers, one per virtual channel (VC0 = even, VC1 = odd), and alternates fill/drain by the global polarity signal.
- Round-robin per VC prevents starvation when several inputs target the same output direction.

Parameters:
- DATA_WIDTH, 64, flit width; bit DATA_WIDTH-1 is the flit's VC bit.
- NUM_REQ, 5, number of requesting input ports; index 0 has the highest initial priority.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  synchronous, active-low; sampled on rising clk.
- polarity  input  1  global even/odd cycle phase, shared by all routers.
- req  input  NUM_REQ  per-input request for this output port.
- req_data  input  NUM_REQ*DATA_WIDTH  flit of requester i at slice [i*DATA_WIDTH +: DATA_WIDTH].
- gnt  output  NUM_REQ  one-hot grant, combinational; requester dequeues on the same rising edge.
- out_so  output  1  registered send strobe to the neighbour (maps to *so).
- out_do  output  DATA_WIDTH  registered flit to the neighbour (maps to *do).
- out_ri  input  1  downstream ready for VC ~polarity (maps to *ri).
- buf_full  output  2  status: bit v = VC v buffer occupied.

Behaviour:
- Reset (reset==0 at posedge):
  - buf_full=2'b00, out_so=0, out_do=0.
  - Both round-robin pointers = 0.
  - gnt=0 while reset is low.
- Fill phase, VC P = polarity:
  - Eligible requester i: req[i]=1 and req_data[i] VC bit == P.
  - Requests whose VC bit != P are not granted this cycle and stay pending.
  - If buffer P is empty and any requester is eligible, grant the first eligible index at or after ptr[P], scanning upward with wrap from NUM_REQ-1 to 0.
  - At the edge: buffer P <= granted flit, buf_full[P] <= 1, ptr[P] <= (granted+1) mod NUM_REQ.
  - If buffer P is full, gnt=0 and the pointer holds.
- Drain phase, VC ~P, same cycle:
  - If buf_full[~P]=1 and out_ri=1: at the edge out_so <= 1, out_do <= buffer ~P, buf_full[~P] <= 0.
  - Otherwise out_so <= 0 and out_do holds its last value.
  - Buffer not full: no send. out_ri=0: stall, the flit stays.
- Fill and drain always touch different buffers, so no conflict between them. A buffer drained in cycle t is refillable in cycle t+1, because polarity has toggled and that VC is now the fill VC.
- Latency: a grant at edge t appears on out_so/out_do at edge t+1 at the earliest, when out_ri=1.
- Single-grant: gnt is one-hot or zero; never more than one bit set.
- Grant never asserts without the matching req bit.
- Flit contents pass through unmodified; hop/direction update belongs to the input side.
- Reset asserted mid-transfer: buffered flits are discarded; out_so=0 on the next cycle.
- Polarity held constant (not toggling): only VC P fills and only VC ~P drains. No deadlock is required in this case; the behaviour is simply as specified.

Optional Feature:
- Macro: VC_ARB_STATS_EN.
- Defined: adds outputs gnt_cnt0, gnt_cnt1, stall_cnt (16 bits each).
  - gnt_cnt0/gnt_cnt1 count grants per VC.
  - stall_cnt counts cycles with buf_full[~polarity]=1 and out_ri=0.
  - All counters saturate at 16'hFFFF and clear on reset.
- Undefined: these ports and counters do not exist; core behaviour is identical.

Test Plan:
1. Reset, then polarity toggling, req=0 for 10 cycles -> gnt=0, out_so=0, buf_full=00 throughout.
2. Polarity=1, req=5'b00001, req_data[0]=64'hD000_0000_1111_1111 (VC bit 1), out_ri=1 -> gnt=00001 that cycle; next cycle (polarity=0) out_so=1 and out_do=64'hD000_0000_1111_1111; buf_full returns to 00.
3. All 5 inputs request VC0 continuously, out_ri=1 -> grants over 5 consecutive even cycles are indices 0,1,2,3,4, then 0 again; no index repeats before all are served.
4. VC1 flit buffered, out_ri=0 for 6 cycles, then 1 -> out_so stays 0 and buf_full[1]=1 for 6 cycles; a new VC1 request gets gnt=0 during the stall; the flit is sent once out_ri=1 in a drain-phase cycle.
5. Grant on req[2], then reset driven low the next cycle -> out_so=0 and buf_full=00 after that edge; no flit emitted after reset releases.
6. VC_ARB_STATS_EN defined: 3 VC0 grants, 2 VC1 grants, 4 stall cycles -> gnt_cnt0=3, gnt_cnt1=2, stall_cnt=4; after 70000 forced stall cycles stall_cnt=16'hFFFF.

Source files
------------

// File: rtl/vc_output_arbiter.sv
// vc_output_arbiter: per-output-port scheduler for the mesh router.
//
// NUM_REQ input requesters (N, S, E, W, PE) share one outbound link.
// There are two single-flit buffers, one per virtual channel (VC0 even, VC1 odd).
// Each cycle the fill VC is P = polarity and the drain VC is ~P, so fill and
// drain never touch the same buffer. Each VC has its own round-robin pointer.
//
// Ports:
//   clk       in   system clock, rising edge
//   reset     in   synchronous active-low reset
//   polarity  in   global even/odd phase; selects the fill VC
//   req       in   [NUM_REQ] per-input request for this output
//   req_data  in   [NUM_REQ*DATA_WIDTH] flit i at [i*DATA_WIDTH +: DATA_WIDTH];
//                  the MSB is the flit's VC bit
//   gnt       out  [NUM_REQ] one-hot combinational grant; requester dequeues on the edge
//   out_so    out  registered send strobe to the neighbour
//   out_do    out  [DATA_WIDTH] registered flit to the neighbour
//   out_ri    in   downstream ready for VC ~polarity
//   buf_full  out  [2] bit v set when the VC v buffer is occupied
//
// Optional build macro VC_ARB_STATS_EN adds the saturating 16-bit counters
// gnt_cnt0, gnt_cnt1 (grants per VC) and stall_cnt (cycles where the drain
// buffer is full and out_ri is low).
module vc_output_arbiter #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned NUM_REQ    = 5
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          polarity,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            gnt,
  output logic                          out_so,
  output logic [DATA_WIDTH-1:0]         out_do,
  input  logic                          out_ri,
  output logic [1:0]                    buf_full
`ifdef VC_ARB_STATS_EN
  ,
  output logic [15:0]                   gnt_cnt0,
  output logic [15:0]                   gnt_cnt1,
  output logic [15:0]                   stall_cnt
`endif
);

  localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned SumW = IdxW + 1;

  logic [DATA_WIDTH-1:0] flit [NUM_REQ];
  logic [NUM_REQ-1:0]    elig;

  logic [DATA_WIDTH-1:0] buf0_q, buf1_q;
  logic [1:0]            buf_full_q, buf_full_d;
  logic [IdxW-1:0]       ptr0_q, ptr1_q;
  logic                  out_so_q;
  logic [DATA_WIDTH-1:0] out_do_q;

  logic                  grant_valid;
  logic [IdxW-1:0]       grant_idx;
  logic [IdxW-1:0]       fill_ptr;
  logic [IdxW-1:0]       ptr_next;
  logic [SumW-1:0]       scan_sum;
  logic [IdxW-1:0]       scan_idx;
  logic                  drain_en;

  // Only requests whose VC bit matches the current fill VC are eligible.
  for (genvar i = 0; i < int'(NUM_REQ); i++) begin : g_req
    assign flit[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    assign elig[i] = req[i] & (flit[i][DATA_WIDTH-1] == polarity);
  end

  // Round-robin scan from the fill VC's pointer, wrapping at NUM_REQ.
  always_comb begin
    fill_ptr    = polarity ? ptr1_q : ptr0_q;
    grant_valid = 1'b0;
    grant_idx   = '0;
    scan_sum    = '0;
    scan_idx    = '0;
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      scan_sum = {1'b0, fill_ptr} + SumW'(k);
      if (scan_sum >= SumW'(NUM_REQ)) scan_sum = scan_sum - SumW'(NUM_REQ);
      scan_idx = scan_sum[IdxW-1:0];
      if (!grant_valid && elig[scan_idx]) begin
        grant_valid = 1'b1;
        grant_idx   = scan_idx;
      end
    end
    // A full fill buffer, or reset held low, blocks any grant.
    if (!reset || buf_full_q[polarity]) grant_valid = 1'b0;
    gnt = '0;
    if (grant_valid) gnt[grant_idx] = 1'b1;
  end

  always_comb begin
    ptr_next   = (grant_idx == IdxW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    drain_en   = buf_full_q[~polarity] & out_ri;
    buf_full_d = buf_full_q;
    if (grant_valid) buf_full_d[polarity] = 1'b1;
    if (drain_en)    buf_full_d[~polarity] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      buf0_q     <= '0;
      buf1_q     <= '0;
      buf_full_q <= 2'b00;
      ptr0_q     <= '0;
      ptr1_q     <= '0;
      out_so_q   <= 1'b0;
      out_do_q   <= '0;
    end else begin
      buf_full_q <= buf_full_d;
      out_so_q   <= drain_en;
      if (drain_en) out_do_q <= polarity ? buf0_q : buf1_q;
      if (grant_valid) begin
        if (polarity) begin
          buf1_q <= flit[grant_idx];
          ptr1_q <= ptr_next;
        end else begin
          buf0_q <= flit[grant_idx];
          ptr0_q <= ptr_next;
        end
      end
    end
  end

  assign out_so   = out_so_q;
  assign out_do   = out_do_q;
  assign buf_full = buf_full_q;

`ifdef VC_ARB_STATS_EN
  logic [15:0] gnt_cnt0_q, gnt_cnt1_q, stall_cnt_q;
  logic        stall_evt;

  assign stall_evt = buf_full_q[~polarity] & ~out_ri;

  always_ff @(posedge clk) begin
    if (!reset) begin
      gnt_cnt0_q  <= '0;
      gnt_cnt1_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (grant_valid && !polarity && gnt_cnt0_q != 16'hFFFF) gnt_cnt0_q <= gnt_cnt0_q + 16'd1;
      if (grant_valid && polarity && gnt_cnt1_q != 16'hFFFF)  gnt_cnt1_q <= gnt_cnt1_q + 16'd1;
      if (stall_evt && stall_cnt_q != 16'hFFFF)               stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign gnt_cnt0  = gnt_cnt0_q;
  assign gnt_cnt1  = gnt_cnt1_q;
  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_vc_output_arbiter.sv
module tb_vc_output_arbiter;

  localparam int DW = 64;
  localparam int NR = 5;

  logic             clk = 1'b0;
  logic             reset;
  logic             polarity;
  logic [NR-1:0]    req;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]    gnt;
  logic             out_so;
  logic [DW-1:0]    out_do;
  logic             out_ri;
  logic [1:0]       buf_full;
`ifdef VC_ARB_STATS_EN
  logic [15:0]      gnt_cnt0, gnt_cnt1, stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vc_output_arbiter #(
    .DATA_WIDTH(DW),
    .NUM_REQ   (NR)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .polarity (polarity),
    .req      (req),
    .req_data (req_data),
    .gnt      (gnt),
    .out_so   (out_so),
    .out_do   (out_do),
    .out_ri   (out_ri),
    .buf_full (buf_full)
`ifdef VC_ARB_STATS_EN
    ,
    .gnt_cnt0 (gnt_cnt0),
    .gnt_cnt1 (gnt_cnt1),
    .stall_cnt(stall_cnt)
`endif
  );

  // Advance one clock; returns 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset    = 1'b0;
    req      = '0;
    req_data = '0;
    polarity = 1'b0;
    out_ri   = 1'b1;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    // Requests present while reset is low must not be granted.
    reset = 1'b0;
    req   = 5'b11111;
    #1;
    checks++;
    if (gnt !== 5'b00000) begin
      errors++;
      $display("FAIL reset_gnt got %b want 00000", gnt);
    end
    tick();
    checks++;
    if (out_so !== 1'b0 || buf_full !== 2'b00 || out_do !== 64'h0) begin
      errors++;
      $display("FAIL reset_state got so=%b full=%b do=%h want 0 00 0", out_so, buf_full, out_do);
    end
    req   = '0;
    reset = 1'b1;
    for (int c = 0; c < 10; c++) begin
      polarity = c[0];
      #1;
      checks++;
      if (gnt !== 5'b00000) begin
        errors++;
        $display("FAIL idle_gnt cyc %0d got %b want 00000", c, gnt);
      end
      tick();
      checks++;
      if (out_so !== 1'b0 || buf_full !== 2'b00) begin
        errors++;
        $display("FAIL idle_state cyc %0d got so=%b full=%b want 0 00", c, out_so, buf_full);
      end
    end
  endtask

  task automatic test_single_vc1();
    do_reset();
    polarity         = 1'b1;
    out_ri           = 1'b1;
    req              = 5'b00001;
    req_data[0+:DW]  = 64'hD000_0000_1111_1111;
    #1;
    checks++;
    if (gnt !== 5'b00001) begin
      errors++;
      $display("FAIL vc1_gnt got %b want 00001", gnt);
    end
    tick();
    checks++;
    if (buf_full !== 2'b10 || out_so !== 1'b0) begin
      errors++;
      $display("FAIL vc1_buffered got full=%b so=%b want 10 0", buf_full, out_so);
    end
    req      = '0;
    polarity = 1'b0;
    tick();
    checks++;
    if (out_so !== 1'b1 || out_do !== 64'hD000_0000_1111_1111 || buf_full !== 2'b00) begin
      errors++;
      $display("FAIL vc1_send got so=%b do=%h full=%b want 1 d000000011111111 00",
               out_so, out_do, buf_full);
    end
    polarity = 1'b1;
    tick();
    checks++;
    if (out_so !== 1'b0 || out_do !== 64'hD000_0000_1111_1111) begin
      errors++;
      $display("FAIL vc1_after got so=%b do=%h want 0 d000000011111111", out_so, out_do);
    end
  endtask

  task automatic test_round_robin();
    logic [DW-1:0] exp_flit;
    logic [NR-1:0] exp_gnt;
    do_reset();
    out_ri = 1'b1;
    req    = 5'b11111;
    for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = 64'h0A00_0000_0000_0000 + 64'(i);
    for (int k = 0; k < 6; k++) begin
      exp_gnt  = 5'b00001 << (k % NR);
      exp_flit = 64'h0A00_0000_0000_0000 + 64'(k % NR);
      polarity = 1'b0;
      #1;
      checks++;
      if (gnt !== exp_gnt) begin
        errors++;
        $display("FAIL rr_gnt round %0d got %b want %b", k, gnt, exp_gnt);
      end
      tick();
      polarity = 1'b1;
      #1;
      checks++;
      if (gnt !== 5'b00000) begin
        errors++;
        $display("FAIL rr_odd_gnt round %0d got %b want 00000", k, gnt);
      end
      tick();
      checks++;
      if (out_so !== 1'b1 || out_do !== exp_flit) begin
        errors++;
        $display("FAIL rr_send round %0d got so=%b do=%h want 1 %h", k, out_so, out_do, exp_flit);
      end
    end
    req = '0;
  endtask

  task automatic test_stall();
    do_reset();
    out_ri           = 1'b0;
    polarity         = 1'b1;
    req              = 5'b00010;
    req_data[1*DW+:DW] = 64'h8000_0000_0000_00AA;
    #1;
    checks++;
    if (gnt !== 5'b00010) begin
      errors++;
      $display("FAIL stall_fill_gnt got %b want 00010", gnt);
    end
    tick();
    // A second VC1 flit waits while the first is stuck.
    req                = 5'b01000;
    req_data[3*DW+:DW] = 64'h8000_0000_0000_00BB;
    for (int c = 0; c < 6; c++) begin
      polarity = c[0];
      #1;
      checks++;
      if (gnt !== 5'b00000) begin
        errors++;
        $display("FAIL stall_gnt cyc %0d got %b want 00000", c, gnt);
      end
      tick();
      checks++;
      if (out_so !== 1'b0 || buf_full[1] !== 1'b1) begin
        errors++;
        $display("FAIL stall_hold cyc %0d got so=%b full=%b want 0 1x", c, out_so, buf_full);
      end
    end
    polarity = 1'b0;
    out_ri   = 1'b1;
    tick();
    checks++;
    if (out_so !== 1'b1 || out_do !== 64'h8000_0000_0000_00AA || buf_full[1] !== 1'b0) begin
      errors++;
      $display("FAIL stall_release got so=%b do=%h full=%b want 1 80000000000000aa 0x",
               out_so, out_do, buf_full);
    end
    // Pointer for VC1 sits at 2 after granting index 1, so index 3 wins.
    polarity = 1'b1;
    #1;
    checks++;
    if (gnt !== 5'b01000) begin
      errors++;
      $display("FAIL stall_next_gnt got %b want 01000", gnt);
    end
    tick();
    req = '0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    out_ri             = 1'b1;
    polarity           = 1'b0;
    req                = 5'b00100;
    req_data[2*DW+:DW] = 64'h0000_0000_CCCC_CCCC;
    #1;
    checks++;
    if (gnt !== 5'b00100) begin
      errors++;
      $display("FAIL midrst_gnt got %b want 00100", gnt);
    end
    tick();
    checks++;
    if (buf_full !== 2'b01) begin
      errors++;
      $display("FAIL midrst_buffered got %b want 01", buf_full);
    end
    req      = '0;
    reset    = 1'b0;
    polarity = 1'b1;
    tick();
    checks++;
    if (out_so !== 1'b0 || buf_full !== 2'b00) begin
      errors++;
      $display("FAIL midrst_clear got so=%b full=%b want 0 00", out_so, buf_full);
    end
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      polarity = c[0];
      tick();
      checks++;
      if (out_so !== 1'b0) begin
        errors++;
        $display("FAIL midrst_no_send cyc %0d got so=%b want 0", c, out_so);
      end
    end
  endtask

`ifdef VC_ARB_STATS_EN
  task automatic test_stats();
    do_reset();
    out_ri             = 1'b1;
    req                = 5'b00011;
    req_data[0*DW+:DW] = 64'h0000_0000_0000_0001;
    req_data[1*DW+:DW] = 64'h8000_0000_0000_0002;
    // Five cycles 0,1,0,1,0: three VC0 grants and two VC1 grants.
    for (int c = 0; c < 5; c++) begin
      polarity = c[0];
      tick();
    end
    req      = '0;
    out_ri   = 1'b0;
    polarity = 1'b1;
    for (int c = 0; c < 4; c++) tick();
    checks++;
    if (gnt_cnt0 !== 16'd3 || gnt_cnt1 !== 16'd2 || stall_cnt !== 16'd4) begin
      errors++;
      $display("FAIL stats_counts got %0d %0d %0d want 3 2 4", gnt_cnt0, gnt_cnt1, stall_cnt);
    end
    for (int c = 0; c < 70000; c++) tick();
    checks++;
    if (stall_cnt !== 16'hFFFF) begin
      errors++;
      $display("FAIL stats_saturate got %h want ffff", stall_cnt);
    end
  endtask
`endif

  initial begin
    reset    = 1'b0;
    polarity = 1'b0;
    req      = '0;
    req_data = '0;
    out_ri   = 1'b0;
    test_reset();
    test_single_vc1();
    test_round_robin();
    test_stall();
    test_reset_mid();
`ifdef VC_ARB_STATS_EN
    test_stats();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
